// File: rtl/as_pack.sv
// rtl/as_pack.sv - shared types and constants for the as_* core support blocks
package as_pack;

  localparam int unsigned nr_gpios = 16;

  localparam int unsigned TM_PASS_CODE = 1;
  localparam int unsigned TM_PROG_CODE = 4;

  typedef enum logic [2:0] {
    TM_IDLE = 3'd0,
    TM_RUN  = 3'd1,
    TM_PASS = 3'd2,
    TM_FAIL = 3'd3,
    TM_TOUT = 3'd4
  } tm_state_t;

  typedef enum logic [1:0] {
    TM_NONE     = 2'd0,
    TM_BADCODE  = 2'd1,
    TM_UNDERRUN = 2'd2,
    TM_TIMEOUT  = 2'd3
  } tm_reason_t;

endpackage

// File: rtl/as_sat_counter.sv
// rtl/as_sat_counter.sv - up counter with synchronous clear that holds at all-ones
module as_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/as_gpio_test_monitor.sv
// rtl/as_gpio_test_monitor.sv - classifies firmware GPIO writes into a PASS/FAIL/TIMEOUT verdict
module as_gpio_test_monitor
  import as_pack::*;
#(
  parameter int unsigned              DATA_W         = nr_gpios,
  parameter logic [DATA_W-1:0]        PASS_CODE      = DATA_W'(TM_PASS_CODE),
  parameter logic [DATA_W-1:0]        PROG_CODE      = DATA_W'(TM_PROG_CODE),
  parameter int unsigned              CNT_W          = 8,
  parameter int unsigned              TOUT_W         = 20,
  parameter int unsigned              TIMEOUT_CYCLES = 100000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              clear_i,
  input  logic [CNT_W-1:0]  exp_progress_i,
  input  logic              cs_i,
  input  logic [DATA_W-1:0] gpio_i,
  output tm_state_t         state_o,
  output logic              done_o,
  output logic              pass_o,
  output tm_reason_t        reason_o,
  output logic [DATA_W-1:0] fail_code_o,
  output logic [CNT_W-1:0]  progress_o,
  output logic [DATA_W-1:0] last_code_o
);

  if (PASS_CODE == PROG_CODE) begin : g_bad_codes
    $error("as_gpio_test_monitor: PASS_CODE must differ from PROG_CODE");
  end
  if (64'(TIMEOUT_CYCLES) >= (64'd1 << TOUT_W)) begin : g_bad_tout
    $error("as_gpio_test_monitor: TIMEOUT_CYCLES does not fit in TOUT_W bits");
  end

  localparam bit                TOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_EN ? TOUT_W'(TIMEOUT_CYCLES - 1) : '0;

  tm_state_t         state_q, state_d;
  tm_reason_t        reason_q, reason_d;
  logic [DATA_W-1:0] fail_q, fail_d;
  logic [DATA_W-1:0] last_q, last_d;

  logic              prog_clr, prog_inc;
  logic              tmr_clr, tmr_inc;
  logic [CNT_W-1:0]  prog_cnt;
  logic [TOUT_W-1:0] tmr_cnt;

  as_sat_counter #(.W(CNT_W)) u_progress (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (prog_clr),
    .inc_i (prog_inc),
    .cnt_o (prog_cnt)
  );

  as_sat_counter #(.W(TOUT_W)) u_idle_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (tmr_clr),
    .inc_i (tmr_inc),
    .cnt_o (tmr_cnt)
  );

  always_comb begin
    state_d  = state_q;
    reason_d = reason_q;
    fail_d   = fail_q;
    last_d   = last_q;
    prog_clr = 1'b0;
    prog_inc = 1'b0;
    tmr_clr  = 1'b0;
    tmr_inc  = 1'b0;

    if (clear_i) begin
      state_d  = TM_IDLE;
      reason_d = TM_NONE;
      fail_d   = '0;
      last_d   = '0;
      prog_clr = 1'b1;
      tmr_clr  = 1'b1;
    end else begin
      unique case (state_q)
        TM_IDLE: begin
          if (enable_i) begin
            state_d = TM_RUN;
            tmr_clr = 1'b1;
          end
        end
        TM_RUN: begin
          if (cs_i) begin
            last_d  = gpio_i;
            tmr_clr = 1'b1;
            if (gpio_i == PROG_CODE) begin
              prog_inc = 1'b1;
            end else if (gpio_i == PASS_CODE) begin
              if (prog_cnt >= exp_progress_i) begin
                state_d = TM_PASS;
              end else begin
                state_d  = TM_FAIL;
                reason_d = TM_UNDERRUN;
                fail_d   = PASS_CODE;
              end
            end else begin
              state_d  = TM_FAIL;
              reason_d = TM_BADCODE;
              fail_d   = gpio_i;
            end
          end else begin
            // A write in the would-be timeout cycle takes the branch above instead.
            tmr_inc = 1'b1;
            if (TOUT_EN && (tmr_cnt == TOUT_LAST)) begin
              state_d  = TM_TOUT;
              reason_d = TM_TIMEOUT;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= TM_IDLE;
      reason_q <= TM_NONE;
      fail_q   <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      reason_q <= reason_d;
      fail_q   <= fail_d;
      last_q   <= last_d;
    end
  end

  assign state_o     = state_q;
  assign done_o      = (state_q == TM_PASS) || (state_q == TM_FAIL) || (state_q == TM_TOUT);
  assign pass_o      = (state_q == TM_PASS);
  assign reason_o    = reason_q;
  assign fail_code_o = fail_q;
  assign progress_o  = prog_cnt;
  assign last_code_o = last_q;

endmodule

// File: tb/tb_as_gpio_test_monitor.sv
// tb/tb_as_gpio_test_monitor.sv - directed and randomized checks of as_gpio_test_monitor against a reference model
module tb_as_gpio_test_monitor;
  import as_pack::*;

  localparam int DW       = 16;
  localparam int CW       = 2;
  localparam int TC       = 16;
  localparam int PROG_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic [CW-1:0] exp_prog = '0;
  logic          cs = 1'b0;
  logic [DW-1:0] gpio = '0;

  tm_state_t     state_o;
  logic          done_o, pass_o;
  tm_reason_t    reason_o;
  logic [DW-1:0] fail_code_o, last_code_o;
  logic [CW-1:0] progress_o;

  int n_cmp = 0;
  int n_err = 0;

  tm_state_t  m_state;
  tm_reason_t m_reason;
  int         m_fail, m_last, m_prog, m_idle;

  as_gpio_test_monitor #(
    .DATA_W(DW), .CNT_W(CW), .TOUT_W(20), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .enable_i(enable), .clear_i(clear),
    .exp_progress_i(exp_prog), .cs_i(cs), .gpio_i(gpio),
    .state_o(state_o), .done_o(done_o), .pass_o(pass_o), .reason_o(reason_o),
    .fail_code_o(fail_code_o), .progress_o(progress_o), .last_code_o(last_code_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = TM_IDLE; m_reason = TM_NONE;
    m_fail = 0; m_last = 0; m_prog = 0; m_idle = 0;
  endtask

  // Verdict rules applied to one cycle's inputs.
  task automatic model_step();
    if (clear) begin
      model_reset();
    end else if (m_state == TM_IDLE) begin
      if (enable) begin m_state = TM_RUN; m_idle = 0; end
    end else if (m_state == TM_RUN) begin
      if (cs) begin
        m_last = int'(gpio);
        m_idle = 0;
        if (int'(gpio) == TM_PROG_CODE) begin
          m_prog = (m_prog + 1 > PROG_MAX) ? PROG_MAX : m_prog + 1;
        end else if (int'(gpio) == TM_PASS_CODE) begin
          if (m_prog >= int'(exp_prog)) m_state = TM_PASS;
          else begin m_state = TM_FAIL; m_reason = TM_UNDERRUN; m_fail = TM_PASS_CODE; end
        end else begin
          m_state = TM_FAIL; m_reason = TM_BADCODE; m_fail = int'(gpio);
        end
      end else begin
        m_idle++;
        if (m_idle == TC) begin m_state = TM_TOUT; m_reason = TM_TIMEOUT; end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},    32'(state_o),     32'(m_state));
    check({tag, ".done"},     32'(done_o),      32'(m_state inside {TM_PASS, TM_FAIL, TM_TOUT}));
    check({tag, ".pass"},     32'(pass_o),      32'(m_state == TM_PASS));
    check({tag, ".reason"},   32'(reason_o),    32'(m_reason));
    check({tag, ".fail"},     32'(fail_code_o), 32'(m_fail));
    check({tag, ".progress"}, 32'(progress_o),  32'(m_prog));
    check({tag, ".last"},     32'(last_code_o), 32'(m_last));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    enable = 1'b0; clear = 1'b0; cs = 1'b0; gpio = '0;
  endtask

  task automatic wr(input int val, input string tag);
    idle(); cs = 1'b1; gpio = DW'(val);
    tick(tag);
    cs = 1'b0;
  endtask

  task automatic restart(input int e);
    idle(); clear = 1'b1; tick("clear");
    idle(); exp_prog = CW'(e); enable = 1'b1; tick("enable");
    idle();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // nominal pass
    restart(1);
    wr(4, "nom.prog");
    wr(1, "nom.pass");
    check("nom.pass_o", 32'(pass_o), 32'd1);
    check("nom.progress", 32'(progress_o), 32'd1);

    // bad code, then sticky
    restart(0);
    wr(4, "bad.prog");
    wr(16'hDEAD, "bad.code");
    check("bad.fail_code", 32'(fail_code_o), 32'hDEAD);
    check("bad.reason", 32'(reason_o), 32'(TM_BADCODE));
    wr(1, "bad.sticky");
    enable = 1'b1; tick("bad.enable_ignored");

    // underrun then successful run
    restart(3);
    wr(4, "ur.p1"); wr(4, "ur.p2"); wr(1, "ur.pass");
    check("ur.reason", 32'(reason_o), 32'(TM_UNDERRUN));
    check("ur.progress", 32'(progress_o), 32'd2);
    restart(3);
    wr(4, "ok.p1"); wr(4, "ok.p2"); wr(4, "ok.p3"); wr(1, "ok.pass");
    check("ok.state", 32'(state_o), 32'(TM_PASS));

    // timeout exactly TC cycles after RUN entry
    restart(0);
    for (int i = 0; i < TC - 1; i++) tick("to.wait");
    check("to.still_run", 32'(state_o), 32'(TM_RUN));
    tick("to.fire");
    check("to.state", 32'(state_o), 32'(TM_TOUT));
    check("to.reason", 32'(reason_o), 32'(TM_TIMEOUT));

    // write in the would-be timeout cycle restarts the count
    restart(0);
    for (int i = 0; i < TC - 1; i++) tick("tw.wait");
    wr(4, "tw.save");
    check("tw.saved", 32'(state_o), 32'(TM_RUN));
    for (int i = 0; i < TC - 1; i++) tick("tw.wait2");
    tick("tw.fire");
    check("tw.state", 32'(state_o), 32'(TM_TOUT));

    // progress saturation
    restart(0);
    for (int i = 0; i < 5; i++) wr(4, "sat.prog");
    check("sat.progress", 32'(progress_o), 32'(PROG_MAX));
    check("sat.state", 32'(state_o), 32'(TM_RUN));

    // cs together with enable in IDLE is ignored
    idle(); clear = 1'b1; tick("ce.clear");
    idle(); enable = 1'b1; cs = 1'b1; gpio = 16'hBEEF; tick("ce.enable");
    check("ce.last", 32'(last_code_o), 32'd0);

    // clear beats a bad write mid-run
    restart(0);
    wr(4, "clr.p1"); wr(4, "clr.p2");
    idle(); clear = 1'b1; cs = 1'b1; gpio = 16'h0BAD; tick("clr.hit");
    check("clr.state", 32'(state_o), 32'(TM_IDLE));

    // asynchronous reset while in PASS
    restart(0);
    wr(1, "ar.pass");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("ar.async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_all("ar.hold");

    // randomized sessions
    for (int s = 0; s < 25; s++) begin
      restart($urandom_range(0, 3));
      for (int c = 0; c < 40; c++) begin
        int pick;
        idle();
        cs = ($urandom_range(0, 3) == 0);
        pick = $urandom_range(0, 9);
        gpio = (pick < 5) ? DW'(TM_PROG_CODE) : (pick < 7) ? DW'(TM_PASS_CODE) : DW'($urandom);
        enable = ($urandom_range(0, 7) == 0);
        clear  = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 19) == 0) exp_prog = CW'($urandom_range(0, 3));
        tick("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
